// File: rtl/load_scoreboard.sv
// Issue-stage scoreboard for outstanding non-blocking loads.
// Blocks RAW/WAW hazards, fences and over-limit loads.
module load_scoreboard #(
  parameter int reg_els_p = 32,
  parameter int max_out_p = 8,
  localparam int reg_addr_width_lp = $clog2(reg_els_p),
  localparam int count_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         issue_v_i,
  input  logic [reg_addr_width_lp-1:0] rs1_i,
  input  logic [reg_addr_width_lp-1:0] rs2_i,
  input  logic [reg_addr_width_lp-1:0] rd_i,
  input  logic                         op_reads_rf1_i,
  input  logic                         op_reads_rf2_i,
  input  logic                         op_writes_rf_i,
  input  logic                         is_load_op_i,
  input  logic                         is_fence_op_i,
  input  logic                         resp_v_i,
  input  logic [reg_addr_width_lp-1:0] resp_rd_i,
  output logic                         stall_o,
  output logic                         issue_accept_o,
  output logic [reg_els_p-1:0]         pending_o,
  output logic [count_width_lp-1:0]    outstanding_o,
  output logic                         empty_o,
  output logic                         error_o
);

  localparam logic [count_width_lp-1:0] max_cnt_lp =
    count_width_lp'(max_out_p);

  logic [reg_els_p-1:0]      pending_r;
  logic [count_width_lp-1:0] count_r;
  logic                      error_r;

  logic [reg_els_p-1:0]      clear_mask;
  logic [reg_els_p-1:0]      set_mask;
  logic [reg_els_p-1:0]      eff_pending;
  logic [count_width_lp-1:0] eff_count;
  logic                      inc, dec;
  logic                      raw1, raw2, waw;
  logic                      fence_blk, full_blk;
  logic                      alloc;
  logic                      err_evt;

  // Returning load clears its entry, bypassed into this cycle's hazards.
  always_comb begin
    clear_mask = '0;
    if (resp_v_i && resp_rd_i != '0)
      clear_mask[resp_rd_i] = 1'b1;
  end

  assign eff_pending = pending_r & ~clear_mask;
  assign dec = resp_v_i & (count_r != '0);
  assign eff_count = count_r - count_width_lp'(dec);

  assign raw1 = op_reads_rf1_i & eff_pending[rs1_i];
  assign raw2 = op_reads_rf2_i & eff_pending[rs2_i];
  assign waw = op_writes_rf_i & eff_pending[rd_i];
  assign fence_blk = is_fence_op_i & (eff_count != '0);
  assign full_blk = is_load_op_i & op_writes_rf_i &
                    (eff_count == max_cnt_lp);

  assign stall_o = issue_v_i &
    (raw1 | raw2 | waw | fence_blk | full_blk);
  assign issue_accept_o = issue_v_i & ~stall_o;

  assign alloc = issue_accept_o & is_load_op_i &
                 op_writes_rf_i & (rd_i != '0);

  // Accepted register-writing load claims its destination.
  always_comb begin
    set_mask = '0;
    if (alloc)
      set_mask[rd_i] = 1'b1;
  end

  assign inc = |set_mask;

  // Response for a register that is not pending, or with none in flight.
  assign err_evt = resp_v_i & (resp_rd_i != '0) &
                   (~pending_r[resp_rd_i] | (count_r == '0));

  // Scoreboard bits, outstanding counter and sticky error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_r <= '0;
      count_r   <= '0;
      error_r   <= 1'b0;
    end else begin
      pending_r <= eff_pending | set_mask;
      case ({inc, dec})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (err_evt)
        error_r <= 1'b1;
    end
  end

  assign pending_o = pending_r;
  assign outstanding_o = count_r;
  assign empty_o = (count_r == '0);
  assign error_o = error_r;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_load_scoreboard;

  logic        clk;
  logic        reset_i;
  logic        issue_v_i;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic        op_reads_rf1_i, op_reads_rf2_i;
  logic        op_writes_rf_i;
  logic        is_load_op_i, is_fence_op_i;
  logic        resp_v_i;
  logic [4:0]  resp_rd_i;
  logic        stall_o, issue_accept_o;
  logic [31:0] pending_o;
  logic [3:0]  outstanding_o;
  logic        empty_o, error_o;

  typedef struct {
    string       name;
    logic        st;
    logic        acc;
    logic [31:0] pend;
    logic [3:0]  outc;
    logic        emp;
    logic        err;
  } rec_t;

  rec_t q[$];
  int total = 0;
  int bad = 0;

  load_scoreboard dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .issue_v_i(issue_v_i),
    .rs1_i(rs1_i),
    .rs2_i(rs2_i),
    .rd_i(rd_i),
    .op_reads_rf1_i(op_reads_rf1_i),
    .op_reads_rf2_i(op_reads_rf2_i),
    .op_writes_rf_i(op_writes_rf_i),
    .is_load_op_i(is_load_op_i),
    .is_fence_op_i(is_fence_op_i),
    .resp_v_i(resp_v_i),
    .resp_rd_i(resp_rd_i),
    .stall_o(stall_o),
    .issue_accept_o(issue_accept_o),
    .pending_o(pending_o),
    .outstanding_o(outstanding_o),
    .empty_o(empty_o),
    .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every queued expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      rec_t e;
      e = q.pop_front();
      total++;
      if (stall_o !== e.st || issue_accept_o !== e.acc ||
          pending_o !== e.pend || outstanding_o !== e.outc ||
          empty_o !== e.emp || error_o !== e.err) begin
        bad++;
        $display("FAIL %s: got st=%b acc=%b pend=%h out=%0d emp=%b err=%b want st=%b acc=%b pend=%h out=%0d emp=%b err=%b",
          e.name, stall_o, issue_accept_o, pending_o,
          outstanding_o, empty_o, error_o,
          e.st, e.acc, e.pend, e.outc, e.emp, e.err);
      end
    end
  end

  task automatic drive(
    input logic iv, input logic [4:0] r1, input logic [4:0] r2,
    input logic [4:0] rd, input logic f1, input logic f2,
    input logic wr, input logic ld, input logic fn,
    input logic rv, input logic [4:0] rrd);
    @(posedge clk);
    #1;
    issue_v_i = iv;
    rs1_i = r1;
    rs2_i = r2;
    rd_i = rd;
    op_reads_rf1_i = f1;
    op_reads_rf2_i = f2;
    op_writes_rf_i = wr;
    is_load_op_i = ld;
    is_fence_op_i = fn;
    resp_v_i = rv;
    resp_rd_i = rrd;
  endtask

  task automatic expect_now(
    input string nm, input logic st, input logic acc,
    input logic [31:0] pend, input logic [3:0] outc,
    input logic err);
    rec_t e;
    e.name = nm;
    e.st = st;
    e.acc = acc;
    e.pend = pend;
    e.outc = outc;
    e.emp = (outc == 4'd0);
    e.err = err;
    q.push_back(e);
  endtask

  task automatic nop(input logic rv, input logic [4:0] rrd);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, rv, rrd);
  endtask

  task automatic ld(input logic [4:0] rd, input logic rv,
                    input logic [4:0] rrd);
    drive(1, 0, 0, rd, 0, 0, 1, 1, 0, rv, rrd);
  endtask

  task automatic alu(input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic rv,
                     input logic [4:0] rrd);
    drive(1, r1, r2, rd, 1, 1, rd != 0, 0, 0, rv, rrd);
  endtask

  task automatic fence(input logic rv, input logic [4:0] rrd);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, rv, rrd);
  endtask

  initial begin
    logic [31:0] pm;
    logic [3:0]  oc;
    int          drain [8] = '{1, 2, 4, 5, 6, 7, 8, 9};

    reset_i = 1'b1;
    issue_v_i = 0; rs1_i = 0; rs2_i = 0; rd_i = 0;
    op_reads_rf1_i = 0; op_reads_rf2_i = 0;
    op_writes_rf_i = 0; is_load_op_i = 0; is_fence_op_i = 0;
    resp_v_i = 0; resp_rd_i = 0;
    repeat (2) @(posedge clk);

    nop(0, 0); reset_i = 1'b0;
    expect_now("reset", 0, 0, 32'h0, 0, 0);

    // RAW on a pending load, released by same-cycle response.
    ld(5, 0, 0);      expect_now("ld5", 0, 1, 32'h0, 0, 0);
    alu(5, 0, 6, 0, 0);
    expect_now("raw1_stall", 1, 0, 32'h20, 1, 0);
    alu(5, 0, 6, 1, 5);
    expect_now("raw1_bypass", 0, 1, 32'h20, 1, 0);
    nop(0, 0);        expect_now("drained", 0, 0, 32'h0, 0, 0);

    // Fill to the outstanding limit.
    pm = 0;
    for (int i = 1; i <= 8; i++) begin
      ld(5'(i), 0, 0);
      expect_now($sformatf("fill%0d", i), 0, 1, pm, 4'(i - 1), 0);
      pm[i] = 1'b1;
    end
    alu(0, 4, 0, 0, 0);
    expect_now("raw2_stall", 1, 0, 32'h1FE, 8, 0);
    ld(9, 0, 0);      expect_now("full_stall", 1, 0, 32'h1FE, 8, 0);
    ld(9, 1, 3);      expect_now("full_bypass", 0, 1, 32'h1FE, 8, 0);
    nop(0, 0);        expect_now("after_swap", 0, 0, 32'h3F6, 8, 0);

    pm = 32'h3F6; oc = 8;
    for (int i = 0; i < 8; i++) begin
      nop(1, 5'(drain[i]));
      expect_now($sformatf("drain%0d", drain[i]), 0, 0, pm, oc, 0);
      pm[drain[i]] = 1'b0;
      oc = oc - 1;
    end

    // WAW on rd=7; set wins over same-cycle clear.
    ld(7, 0, 0);      expect_now("ld7", 0, 1, 32'h0, 0, 0);
    ld(7, 0, 0);      expect_now("waw_stall", 1, 0, 32'h80, 1, 0);
    ld(7, 1, 7);      expect_now("waw_bypass", 0, 1, 32'h80, 1, 0);
    nop(0, 0);        expect_now("set_wins", 0, 0, 32'h80, 1, 0);
    nop(1, 7);        expect_now("resp7", 0, 0, 32'h80, 1, 0);

    // Fence waits for all loads.
    ld(10, 0, 0);     expect_now("ld10", 0, 1, 32'h0, 0, 0);
    ld(11, 0, 0);     expect_now("ld11", 0, 1, 32'h400, 1, 0);
    fence(0, 0);      expect_now("fence_st2", 1, 0, 32'hC00, 2, 0);
    fence(1, 10);     expect_now("fence_st1", 1, 0, 32'hC00, 2, 0);
    fence(1, 11);     expect_now("fence_go", 0, 1, 32'h800, 1, 0);
    fence(0, 0);      expect_now("fence_empty", 0, 1, 32'h0, 0, 0);

    // Loads to x0 and reads of x0.
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    expect_now("ld_x0", 0, 1, 32'h0, 0, 0);
    alu(0, 0, 3, 0, 0);
    expect_now("alu_x0", 0, 1, 32'h0, 0, 0);
    nop(1, 0);        expect_now("resp_x0", 0, 0, 32'h0, 0, 0);
    nop(0, 0);        expect_now("no_alloc", 0, 0, 32'h0, 0, 0);

    // Spurious response and sticky error.
    nop(1, 12);       expect_now("spurious", 0, 0, 32'h0, 0, 0);
    nop(0, 0);        expect_now("err_set", 0, 0, 32'h0, 0, 1);
    nop(0, 0);        expect_now("err_sticky", 0, 0, 32'h0, 0, 1);

    // Reset with three loads in flight.
    ld(1, 0, 0);      expect_now("rl1", 0, 1, 32'h0, 0, 1);
    ld(2, 0, 0);      expect_now("rl2", 0, 1, 32'h2, 1, 1);
    ld(3, 0, 0);      expect_now("rl3", 0, 1, 32'h6, 2, 1);
    nop(0, 0); reset_i = 1'b1;
    expect_now("pre_reset", 0, 0, 32'hE, 3, 1);
    nop(0, 0); reset_i = 1'b0;
    expect_now("post_reset", 0, 0, 32'h0, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_left: got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
